// File: rtl/ifu_fetch_master.sv
// ifu_fetch_master: AXI4-Lite read initiator (AR+R) that fetches one word per PC and hands it to decode
//  clk_i/rst_ni             clock, asynchronous active-low reset
//  fetch_en_i               allows IDLE->REQ
//  araddr_o/arvalid_o/arready_i, rdata_i/rresp_i/rvalid_i/rready_o   AXI4-Lite read channels
//  inst_o/inst_pc_o/inst_err_o/inst_valid_o/inst_ready_i             decode handoff
//  redirect_valid_i/redirect_pc_i                                    pipeline redirect
module ifu_fetch_master #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_err_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT_R = 2'd2, HOLD = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic        kill_q, kill_d, inst_err_q, inst_err_d;
  logic [31:0] tgt;
  assign tgt = redirect_pc_i & ~32'd3;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;
    case (state_q)
      IDLE: begin
        pc_d    = redirect_valid_i ? tgt : pc_q;
        state_d = fetch_en_i ? REQ : IDLE;
      end
      // the outstanding address must not move, so a redirect here is only recorded
      REQ: begin
        npc_d   = redirect_valid_i ? tgt : npc_q;
        kill_d  = kill_q | redirect_valid_i;
        state_d = arready_i ? WAIT_R : REQ;
      end
      WAIT_R: begin
        npc_d  = redirect_valid_i ? tgt : npc_q;
        kill_d = kill_q | redirect_valid_i;
        // squashed word: drop it and resume at the latest redirect target
        if (rvalid_i && (kill_q || redirect_valid_i)) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          pc_d    = redirect_valid_i ? tgt : npc_q;
        end else if (rvalid_i) begin
          state_d    = HOLD;
          inst_d     = rdata_i;
          inst_pc_d  = pc_q;
          inst_err_d = |rresp_i;
        end
      end
      default: begin
        state_d = (redirect_valid_i || inst_ready_i) ? IDLE : HOLD;
        pc_d    = redirect_valid_i ? tgt : inst_ready_i ? pc_q + PC_STEP : pc_q;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
    end
  end
  assign araddr_o     = pc_q;
  assign arvalid_o    = state_q == REQ;
  assign rready_o     = state_q == WAIT_R;
  assign inst_valid_o = state_q == HOLD;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_err_o   = inst_err_q;
endmodule

// File: tb/tb_ifu_fetch_master.sv
// tb_ifu_fetch_master: random AXI responder/decode/redirect stimulus with a transaction-level scoreboard
module tb_ifu_fetch_master;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  logic        clk = 0, rst_ni = 0, fetch_en = 0, arready = 0, rvalid = 0, inst_ready = 0, redirect_valid = 0;
  logic [31:0] rdata = 0, redirect_pc = 0;
  logic [1:0]  rresp = 0;
  logic [31:0] araddr, inst, inst_pc;
  logic        arvalid, rready, inst_err, inst_valid;
  typedef struct packed {logic [31:0] d; logic [31:0] pc; logic e;} item_t;
  item_t sb[$];
  int checks = 0, errors = 0;
  ifu_fetch_master dut (
    .clk_i(clk), .rst_ni(rst_ni), .fetch_en_i(fetch_en),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_err_o(inst_err), .inst_valid_o(inst_valid),
    .inst_ready_i(inst_ready), .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_araddr"}, araddr, RESET_PC);
  endtask
  // stimulus + reference model: the model tracks where the next fetch must go and which
  // returned beats decode should see, from transaction events only
  initial begin
    logic [31:0] exp_pc, pend, tgt;
    bit drop, busy, want_rst, drain;
    int dly;
    exp_pc = RESET_PC; pend = 0; drop = 0; busy = 0; dly = 0; want_rst = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_inst", inst, 0);
    chk("reset_inst_pc", inst_pc, 0);
    chk("reset_inst_err", inst_err, 0);
    rst_ni = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drain = cyc >= 2960;
      if (!drain && cyc % 500 == 250) want_rst = 1;
      if (want_rst && rready) begin
        fetch_en = 1; arready = 0; rvalid = 0; redirect_valid = 0; inst_ready = 0;
        #3 rst_ni = 0;
        #1 chk_idle_outputs("midreset");
        rst_ni = 1;
        exp_pc = RESET_PC; drop = 0; busy = 0; dly = 0; want_rst = 0;
        sb.delete();
        continue;
      end
      fetch_en       = drain ? 1'b0 : ($urandom % 8 != 0);
      arready        = $urandom % 3 != 0;
      inst_ready     = drain || ($urandom % 2 == 1);
      redirect_valid = !drain && ($urandom % 10 == 0);
      redirect_pc    = ($urandom % 4 == 0) ? (32'hFFFF_FFF8 | 32'($urandom % 4)) : $urandom;
      rvalid         = busy && dly == 0;
      rdata          = $urandom;
      rresp          = ($urandom % 4 == 0) ? 2'($urandom % 3 + 1) : 2'b00;
      #1;
      tgt = redirect_pc & ~32'd3;
      if (busy && dly > 0) dly--;
      if (arvalid && arready) begin
        chk("ar_addr", araddr, exp_pc);
        busy = 1;
        dly  = $urandom % 3;
      end
      if (!arvalid && !rready && !inst_valid && redirect_valid) exp_pc = tgt;
      if (arvalid && redirect_valid) begin pend = tgt; drop = 1; end
      if (rready && rvalid) begin
        busy = 0;
        if (drop || redirect_valid) begin
          exp_pc = redirect_valid ? tgt : pend;
          drop   = 0;
        end else sb.push_back('{d: rdata, pc: exp_pc, e: (rresp != 2'b00)});
      end else if (rready && redirect_valid) begin
        pend = tgt; drop = 1;
      end
      if (inst_valid) exp_pc = redirect_valid ? tgt : inst_ready ? exp_pc + 32'd4 : exp_pc;
    end
    @(negedge clk);
    #3;
    chk("drain_scoreboard_empty", 32'(sb.size()), 0);
    chk("drain_arvalid", arvalid, 0);
    chk("drain_inst_valid", inst_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  // monitor: pops an expectation each time decode is offered a new word, checks it stays
  // stable while held, and checks a pending read address is never retracted or changed
  initial begin
    item_t cur;
    bit was, lp;
    logic [31:0] la;
    cur = '0; was = 0; lp = 0; la = 0;
    forever begin
      @(negedge clk);
      #2;
      if (lp) begin
        chk("ar_hold_valid", arvalid, 1);
        chk("ar_hold_addr", araddr, la);
      end
      lp = arvalid && !arready;
      la = araddr;
      if (inst_valid && !was) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL inst_unexpected actual_pc=%h expected=no_word", inst_pc);
        end else begin
          cur = sb.pop_front();
          chk("inst_data", inst, cur.d);
          chk("inst_pc", inst_pc, cur.pc);
          chk("inst_err", inst_err, cur.e);
        end
      end else if (inst_valid) begin
        chk("hold_inst", inst, cur.d);
        chk("hold_inst_pc", inst_pc, cur.pc);
        chk("hold_inst_err", inst_err, cur.e);
      end
      was = inst_valid;
    end
  end
endmodule
